// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU, single-cycle logic ops and iterative 1-bit-per-cycle shifts
// The first shift step happens at the start edge, so a shift by n finishes after n-1 RUN cycles.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUopr,
    input  logic             SUBorSRA,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [SHAMT_W-1:0] SHAMT_ONE = 1;
    state_t state, state_n;
    logic [WIDTH-1:0] sreg, first, step, alu;
    logic [SHAMT_W-1:0] cnt, shamt;
    logic left, arith, issue, go_run, fin;
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic l, input logic a);
        return l ? {v[WIDTH-2:0], 1'b0} : {a & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction
    assign shamt = operandB[SHAMT_W-1:0];
    assign first = shamt == '0 ? operandA : shift1(operandA, ~ALUopr[2], SUBorSRA);
    assign step  = shift1(sreg, left, arith);
    always_comb begin
        alu = '0;
        case (ALUopr)
            3'b000: alu = SUBorSRA ? operandA - operandB : operandA + operandB;
            3'b010: alu = {{(WIDTH-1){1'b0}}, $signed(operandA) < $signed(operandB)};
            3'b011: alu = {{(WIDTH-1){1'b0}}, operandA < operandB};
            3'b100: alu = operandA ^ operandB;
            3'b110: alu = operandA | operandB;
            3'b111: alu = operandA & operandB;
            default: alu = first;
        endcase
    end
    always_comb begin
        issue   = state == IDLE && start;
        go_run  = issue && ALUopr[1:0] == 2'b01 && shamt > SHAMT_ONE;
        fin     = state == RUN && cnt == SHAMT_ONE;
        state_n = go_run ? RUN : fin ? IDLE : state;
        busy    = state == RUN;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            sreg   <= '0;
            cnt    <= '0;
            left   <= 1'b0;
            arith  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go_run) begin
                sreg  <= first;
                cnt   <= shamt - SHAMT_ONE;
                left  <= ~ALUopr[2];
                arith <= SUBorSRA;
            end else if (issue) begin
                result <= alu;
                zero   <= alu == '0;
                done   <= 1'b1;
            end else if (state == RUN) begin
                sreg <= step;
                cnt  <= cnt - SHAMT_ONE;
                if (fin) begin
                    result <= step;
                    zero   <= step == '0;
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule
